// File: rtl/bus_pkg.sv
// Shared types and constants for the I/D cache memory-bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWdata,
    StResp
  } arb_state_t;

  // 512-bit line over a 64-bit bus
  localparam int unsigned LINE_BEATS = 8;
  // Tag bit that marks a read (line fill); clear means writeback
  localparam int unsigned RD_TAG_BIT = 12;

  localparam logic [12:0] TAG_ICACHE_RD = 13'b1_0001_0000_0000;
  localparam logic [12:0] TAG_DCACHE_RD = 13'b1_0010_0000_0000;
  localparam logic [12:0] TAG_DCACHE_WR = 13'b0_0001_0000_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not win last time.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  // Combinational pick; winner_o is only meaningful when valid_o is set
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = ~last_grant_i;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one tagged memory-bus port between the I-cache (master 0) and the
// D-cache (master 1). One transaction outstanding; the grant is held until
// the address beat plus either the write beats or the response beats finish.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS_PER_LINE = LINE_BEATS,
  parameter int unsigned READ_TAG_BIT   = RD_TAG_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_reqcyc,
  input  logic                      d_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_req,
  input  logic [BUS_DATA_WIDTH-1:0] d_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
  input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
  output logic                      i_reqack,
  output logic                      d_reqack,
  output logic                      i_respcyc,
  output logic                      d_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] i_resp,
  output logic [BUS_DATA_WIDTH-1:0] d_resp,
  output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
  output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
  input  logic                      i_respack,
  input  logic                      d_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int unsigned     CntW     = $clog2(BEATS_PER_LINE) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS_PER_LINE - 1);

  arb_state_t      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            is_read_q, is_read_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic                      grant_valid;
  logic                      grant_winner;
  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  logic                      fwd;
  logic                      in_resp;
  logic                      req_hs;
  logic                      resp_hs;

  rr_arbiter2 u_rr (
    .req0_i      (i_reqcyc),
    .req1_i      (d_reqcyc),
    .last_grant_i(last_grant_q),
    .valid_o     (grant_valid),
    .winner_o    (grant_winner)
  );

  // Select the current owner's request-side inputs
  always_comb begin
    if (owner_q) begin
      own_reqcyc  = d_reqcyc;
      own_req     = d_req;
      own_reqtag  = d_reqtag;
      own_respack = d_respack;
    end else begin
      own_reqcyc  = i_reqcyc;
      own_req     = i_req;
      own_reqtag  = i_reqtag;
      own_respack = i_respack;
    end
  end

  // Gating by reset keeps every control output low while reset is held,
  // even before the synchronous reset has taken effect at the next edge.
  assign fwd     = reset && ((state_q == StAddr) || (state_q == StWdata));
  assign in_resp = reset && (state_q == StResp);
  assign req_hs  = fwd && own_reqcyc && bus_reqack;
  assign resp_hs = in_resp && bus_respcyc && own_respack;

  // Next-state logic for the grant / transfer sequence
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_read_d    = is_read_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d      = grant_winner;
          last_grant_d = grant_winner;
          is_read_d    = grant_winner ? d_reqtag[READ_TAG_BIT] : i_reqtag[READ_TAG_BIT];
          state_d      = StAddr;
        end
      end
      StAddr: begin
        if (!own_reqcyc) begin
          // Owner abandoned the request before the bus took the address
          state_d = StIdle;
        end else if (bus_reqack) begin
          cnt_d   = '0;
          state_d = is_read_q ? StResp : StWdata;
        end
      end
      StWdata: begin
        if (own_reqcyc && bus_reqack) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StResp: begin
        if (bus_respcyc && own_respack) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_read_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_read_q    <= is_read_d;
      cnt_q        <= cnt_d;
    end
  end

  // Request path: forward the owner only; bus_reqack never feeds bus_reqcyc
  assign bus_reqcyc = fwd && own_reqcyc;
  assign bus_req    = fwd ? own_req : '0;
  assign bus_reqtag = fwd ? own_reqtag : '0;
  assign i_reqack   = fwd && !owner_q && bus_reqack;
  assign d_reqack   = fwd && owner_q && bus_reqack;

  // Response path: data/tag broadcast, only respcyc qualifies them
  assign i_respcyc   = in_resp && !owner_q && bus_respcyc;
  assign d_respcyc   = in_resp && owner_q && bus_respcyc;
  assign i_resp      = bus_resp;
  assign d_resp      = bus_resp;
  assign i_resptag   = bus_resptag;
  assign d_resptag   = bus_resptag;
  assign bus_respack = resp_hs;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: random I/D transactions against a random
// bus slave, with expected bus beats and per-master responses queued up front.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 13;
  localparam int unsigned NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_reqcyc, d_reqcyc, i_reqack, d_reqack;
  logic [DW-1:0] i_req, d_req, i_resp, d_resp, bus_req, bus_resp;
  logic [TW-1:0] i_reqtag, d_reqtag, i_resptag, d_resptag, bus_reqtag, bus_resptag;
  logic          i_respcyc, d_respcyc, i_respack, d_respack;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  always #5 clk = ~clk;

  bus_arbiter #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .BEATS_PER_LINE(NB),
    .READ_TAG_BIT  (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_reqcyc   (i_reqcyc),
    .d_reqcyc   (d_reqcyc),
    .i_req      (i_req),
    .d_req      (d_req),
    .i_reqtag   (i_reqtag),
    .d_reqtag   (d_reqtag),
    .i_reqack   (i_reqack),
    .d_reqack   (d_reqack),
    .i_respcyc  (i_respcyc),
    .d_respcyc  (d_respcyc),
    .i_resp     (i_resp),
    .d_resp     (d_resp),
    .i_resptag  (i_resptag),
    .d_resptag  (d_resptag),
    .i_respack  (i_respack),
    .d_respack  (d_respack),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    bit            is_addr;
    bit            rd;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } resp_t;

  beat_t exp_bus[$];
  resp_t exp_i[$];
  resp_t exp_d[$];
  int    checks = 0;
  int    errors = 0;
  int    last_m;
  int    resp_owner = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata(input int m, input logic [DW-1:0] a, input int b);
    return a ^ (64'hC0DE_0000_0000_0000 | (64'(m) << 32) | 64'(b));
  endfunction

  function automatic logic [DW-1:0] rdata(input logic [DW-1:0] a, input int b);
    return a + 64'hA0 + 64'(b);
  endfunction

  function automatic logic [TW-1:0] tag_of(input int m, input bit rd);
    if (m == 0) return TAG_ICACHE_RD;
    return rd ? TAG_DCACHE_RD : TAG_DCACHE_WR;
  endfunction

  // Reference: the beats a transaction must put on the bus, in order
  task automatic push_txn(input int m, input bit rd, input logic [DW-1:0] a);
    beat_t e;
    e.m = m; e.rd = rd; e.tag = tag_of(m, rd); e.is_addr = 1'b1; e.data = a;
    exp_bus.push_back(e);
    if (!rd) begin
      for (int b = 0; b < int'(NB); b++) begin
        e.is_addr = 1'b0;
        e.data    = wdata(m, a, b);
        exp_bus.push_back(e);
      end
    end
  endtask

  task automatic drive_req(input int m, input logic c, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
    if (m == 0) begin
      i_reqcyc = c; i_req = d; i_reqtag = t;
    end else begin
      d_reqcyc = c; d_req = d; d_reqtag = t;
    end
  endtask

  task automatic set_respack(input int m, input logic v);
    if (m == 0) i_respack = v;
    else d_respack = v;
  endtask

  // Master behaviour: address beat, write beats, then collect read responses
  task automatic master_txn(input int m, input bit rd, input logic [DW-1:0] a);
    logic [TW-1:0] t;
    resp_t         r;
    bit            got;
    int            waited;
    int            n;
    int            nbeats;
    t = tag_of(m, rd);
    if (rd) begin
      for (int b = 0; b < int'(NB); b++) begin
        r.data = rdata(a, b);
        r.tag  = t;
        if (m == 0) exp_i.push_back(r);
        else exp_d.push_back(r);
      end
    end
    nbeats = rd ? 1 : 1 + int'(NB);
    for (int b = 0; b < nbeats; b++) begin
      drive_req(m, 1'b1, (b == 0) ? a : wdata(m, a, b - 1), t);
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 1000) begin
        @(negedge clk);
        got = (m == 0) ? i_reqack : d_reqack;
        @(posedge clk);
        #1;
        waited++;
      end
      chk($sformatf("m%0d req beat %0d accepted", m, b), 64'(got), 64'd1);
      if (!got) begin
        drive_req(m, 1'b0, '0, '0);
        return;
      end
    end
    drive_req(m, 1'b0, '0, '0);
    if (rd) begin
      n      = 0;
      waited = 0;
      while (n < int'(NB) && waited < 1000) begin
        set_respack(m, $urandom_range(0, 3) != 0);
        @(negedge clk);
        got = (m == 0) ? (i_respcyc && i_respack) : (d_respcyc && d_respack);
        @(posedge clk);
        #1;
        waited++;
        if (got) n++;
      end
      set_respack(m, 1'b0);
      chk($sformatf("m%0d response beats", m), 64'(n), 64'(NB));
    end
  endtask

  // Bus slave: random reqack, 8 response beats per read with random gaps
  task automatic bus_slave();
    bit            hs_req, hs_resp;
    logic [DW-1:0] rq, r_base;
    logic [TW-1:0] rt, r_tag;
    int            wr_left, r_idx, r_n;
    wr_left = 0; r_idx = 0; r_n = 0; r_base = '0; r_tag = '0;
    forever begin
      @(negedge clk);
      hs_req  = bus_reqcyc && bus_reqack;
      hs_resp = bus_respcyc && bus_respack;
      rq      = bus_req;
      rt      = bus_reqtag;
      @(posedge clk);
      #1;
      if (hs_req) begin
        if (wr_left > 0) wr_left--;
        else if (rt[RD_TAG_BIT]) begin
          r_base = rq; r_tag = rt; r_idx = 0; r_n = int'(NB);
        end else wr_left = int'(NB);
      end
      if (hs_resp) r_idx++;
      if (r_n != 0 && r_idx >= r_n) begin
        r_n = 0; r_idx = 0;
      end
      if (!(bus_respcyc && !hs_resp)) begin
        bus_respcyc = (r_idx < r_n) && ($urandom_range(0, 2) != 0);
        bus_resp    = bus_respcyc ? rdata(r_base, r_idx) : '0;
        bus_resptag = bus_respcyc ? r_tag : '0;
      end
      bus_reqack = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a beat
  task automatic monitor();
    beat_t e;
    resp_t r;
    int    act_m;
    forever begin
      @(negedge clk);
      if (bus_reqcyc && bus_reqack) begin
        if (exp_bus.size() == 0) begin
          chk("unexpected bus request beat", bus_req, '0);
        end else begin
          e = exp_bus.pop_front();
          act_m = (i_reqack && !d_reqack) ? 0 : (d_reqack && !i_reqack) ? 1 : 3;
          chk("bus beat owner", 64'(act_m), 64'(e.m));
          chk("bus_req", bus_req, e.data);
          chk("bus_reqtag", 64'(bus_reqtag), 64'(e.tag));
          if (e.is_addr && e.rd) resp_owner = e.m;
        end
      end
      if (bus_respcyc) begin
        chk("bus_respack", 64'(bus_respack),
            64'((resp_owner == 0) ? i_respack : d_respack));
        chk("owner respcyc", 64'((resp_owner == 0) ? i_respcyc : d_respcyc), 64'd1);
        chk("non-owner respcyc", 64'((resp_owner == 0) ? d_respcyc : i_respcyc), 64'd0);
      end
      if (i_respcyc && i_respack) begin
        if (exp_i.size() == 0) chk("unexpected i response", i_resp, '0);
        else begin
          r = exp_i.pop_front();
          chk("i_resp", i_resp, r.data);
          chk("i_resptag", 64'(i_resptag), 64'(r.tag));
        end
      end
      if (d_respcyc && d_respack) begin
        if (exp_d.size() == 0) chk("unexpected d response", d_resp, '0);
        else begin
          r = exp_d.pop_front();
          chk("d_resp", d_resp, r.data);
          chk("d_resptag", 64'(d_resptag), 64'(r.tag));
        end
      end
    end
  endtask

  task automatic chk_quiet(input string where);
    chk({where, " bus_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    chk({where, " bus_req"}, bus_req, '0);
    chk({where, " reqacks"}, 64'({i_reqack, d_reqack}), 64'd0);
    chk({where, " respcycs"}, 64'({i_respcyc, d_respcyc}), 64'd0);
    chk({where, " bus_respack"}, 64'(bus_respack), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] a0, a1;
    bit            drd;
    int            kind, first;

    reset = 1'b0;
    drive_req(0, 1'b1, 64'h1000, 13'h1100);
    drive_req(1, 1'b0, '0, '0);
    i_respack = 1'b0; d_respack = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;

    // Reset held with a pending I request
    repeat (2) begin
      @(negedge clk);
      chk_quiet("in reset");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("idle grant cycle");
    @(negedge clk);
    chk("addr bus_reqcyc", 64'(bus_reqcyc), 64'd1);
    chk("addr bus_req", bus_req, 64'h1000);
    chk("addr bus_reqtag", 64'(bus_reqtag), 64'h1100);
    chk("addr reqacks no bus ack", 64'({i_reqack, d_reqack}), 64'd0);
    @(posedge clk); #1;
    i_reqcyc = 1'b0;
    @(negedge clk);
    chk("abandon bus_reqcyc", 64'(bus_reqcyc), 64'd0);

    // Read, then reset while response beat 3 is on the bus
    @(posedge clk); #1;
    drive_req(0, 1'b1, 64'h2000, 13'h1100);
    bus_reqack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("i_reqack mirrors bus_reqack", 64'(i_reqack), 64'd1);
    chk("d_reqack idle", 64'(d_reqack), 64'd0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, '0);
    bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = rdata(64'h2000, 0);
    bus_resptag = 13'h1100; i_respack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("dir i_respcyc", 64'(i_respcyc), 64'd1);
      chk("dir bus_respack", 64'(bus_respack), 64'd1);
      chk("dir d_respcyc", 64'(d_respcyc), 64'd0);
      chk("dir i_resp", i_resp, rdata(64'h2000, b));
      @(posedge clk); #1;
      bus_resp = rdata(64'h2000, b + 1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("reset mid resp");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("respcyc outside resp: bus_respack", 64'(bus_respack), 64'd0);
    chk("respcyc outside resp: i_respcyc", 64'(i_respcyc), 64'd0);
    @(posedge clk); #1;
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0; i_respack = 1'b0;
    last_m = 1;

    fork
      bus_slave();
      monitor();
    join_none

    // Random scenarios; the first is a fresh D-cache writeback after reset
    for (int s = 0; s < 30; s++) begin
      kind = (s == 0) ? 1 : $urandom_range(0, 3);
      a0 = {$urandom(), $urandom()}; a0[5:0] = '0;
      a1 = {$urandom(), $urandom()}; a1[5:0] = '0;
      drd = (s == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          push_txn(0, 1'b1, a0);
          last_m = 0;
          master_txn(0, 1'b1, a0);
        end
        1: begin
          push_txn(1, drd, a1);
          last_m = 1;
          master_txn(1, drd, a1);
        end
        default: begin
          // Simultaneous request from idle: the master not granted last wins
          first = 1 - last_m;
          if (first == 0) begin
            push_txn(0, 1'b1, a0);
            push_txn(1, drd, a1);
            last_m = 1;
          end else begin
            push_txn(1, drd, a1);
            push_txn(0, 1'b1, a0);
            last_m = 0;
          end
          fork
            master_txn(0, 1'b1, a0);
            master_txn(1, drd, a1);
          join
        end
      endcase
      @(negedge clk);
      chk("scenario bus beats drained", 64'(exp_bus.size()), 64'd0);
      chk("scenario responses drained", 64'(exp_i.size() + exp_d.size()), 64'd0);
      chk("scenario end bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
